// File: rtl/prog_loader.sv
// Serial program loader: receives an 8N1 UART program image, writes it into
// the instruction store and holds the CPU until the checksum has been verified.
//
// state   | meaning
// IDLE    | waiting for the word-count byte
// WORD_B0 | waiting for instr[17:16] byte
// WORD_B1 | waiting for instr[15:8] byte
// WORD_B2 | waiting for instr[7:0] byte
// WRITE   | one-cycle instruction memory write
// CSUM    | waiting for the checksum byte
// DONE    | image verified, CPU released
// ERROR   | framing/format/checksum error latched
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int AW           = 6,
  parameter int IW           = 18
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          rx,
  input  logic          start,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int MAXW = 1 << AW;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_WORD_B0, S_WORD_B1, S_WORD_B2, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_st_q, rx_st_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frame_err;

  state_t          state_q, state_d;
  logic [7:0]      csum_q;
  logic [AW:0]     n_q, words_q;
  logic [1:0]      b0_q;
  logic [7:0]      b1_q;
  logic [AW-1:0]   addr_q;
  logic [IW-1:0]   data_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= R_IDLE;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  // Down-counting bit timer; every sample is taken at terminal count.
  always_comb begin
    rx_st_d    = rx_st_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_st_d = R_START;
          tmr_d   = CW'(CLKS_PER_BIT / 2 - 1);
        end
      end
      R_START: begin
        if (tmr_q == '0) begin
          if (!rx_sync_q) begin
            rx_st_d   = R_DATA;
            tmr_d     = CW'(CLKS_PER_BIT - 1);
            bit_cnt_d = '0;
          end else begin
            rx_st_d = R_IDLE;
          end
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end
      R_DATA: begin
        if (tmr_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          tmr_d   = CW'(CLKS_PER_BIT - 1);
          if (bit_cnt_q == 3'd7) rx_st_d = R_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end
      R_STOP: begin
        if (tmr_q == '0) begin
          rx_st_d    = R_IDLE;
          byte_vld_d = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_err)       state_d = S_ERROR;
        else if (byte_vld_q) state_d = (shift_q > 8'(MAXW)) ? S_ERROR : S_WORD_B0;
      end
      S_WORD_B0: begin
        if (frame_err)       state_d = S_ERROR;
        else if (byte_vld_q) state_d = (|shift_q[7:2]) ? S_ERROR : S_WORD_B1;
      end
      S_WORD_B1: begin
        if (frame_err)       state_d = S_ERROR;
        else if (byte_vld_q) state_d = S_WORD_B2;
      end
      S_WORD_B2: begin
        if (frame_err)       state_d = S_ERROR;
        else if (byte_vld_q) state_d = S_WRITE;
      end
      S_WRITE: state_d = ((words_q + 1'b1) < n_q) ? S_WORD_B0 : S_CSUM;
      S_CSUM: begin
        if (frame_err)       state_d = S_ERROR;
        else if (byte_vld_q) state_d = (shift_q == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_we      = (state_q == S_WRITE);
    done         = (state_q == S_DONE);
    cpu_hold     = (state_q != S_DONE);
    err          = (state_q == S_ERROR);
    imem_addr    = addr_q;
    imem_data    = data_q;
    words_loaded = words_q;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      csum_q  <= '0;
      n_q     <= '0;
      words_q <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (byte_vld_q && (state_q inside {S_IDLE, S_WORD_B0, S_WORD_B1, S_WORD_B2}))
        csum_q <= csum_q ^ shift_q;
      if (byte_vld_q) begin
        case (state_q)
          S_IDLE:    n_q  <= (shift_q == 8'd0) ? (AW+1)'(MAXW) : (AW+1)'(shift_q);
          S_WORD_B0: b0_q <= shift_q[1:0];
          S_WORD_B1: b1_q <= shift_q;
          S_WORD_B2: begin
            data_q <= IW'({b0_q, b1_q, shift_q});
            addr_q <= words_q[AW-1:0];
          end
          default: ;
        endcase
      end
      if (state_q == S_WRITE) words_q <= words_q + 1'b1;
      if (start && (state_q == S_DONE || state_q == S_ERROR)) begin
        words_q <= '0;
        csum_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as frames are
// sent and popped as imem_we strobes appear.
module tb_prog_loader;
  localparam int CPB = 8;
  localparam int AW  = 6;
  localparam int IW  = 18;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          rx = 1'b1;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          cpu_hold, done, err;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int w0;
  logic [AW+IW-1:0] exp_q[$];
  logic [IW-1:0]    wtab[64];

  prog_loader #(.CLKS_PER_BIT(CPB), .AW(AW), .IW(IW)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .rx(rx), .start(start),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (RESET_N && imem_we) begin
      logic [AW+IW-1:0] e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("spurious_write_qsize", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[AW+IW-1:IW]));
        check("wr_data", 32'(imem_data), 32'(e[IW-1:0]));
      end
    end
  end

  task automatic uart_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge CLOCK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLOCK);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge CLOCK);
    rx = 1'b1;
    repeat (CPB) @(negedge CLOCK);
  endtask

  task automatic send_load(input int n, input logic corrupt);
    logic [7:0] cs, b0, b1, b2;
    cs = (n == 64) ? 8'h00 : 8'(n);
    uart_byte(cs);
    for (int i = 0; i < n; i++) begin
      b0 = {6'b0, wtab[i][17:16]};
      b1 = wtab[i][15:8];
      b2 = wtab[i][7:0];
      cs = cs ^ b0 ^ b1 ^ b2;
      uart_byte(b0);
      uart_byte(b1);
      exp_q.push_back({6'(i), wtab[i]});
      uart_byte(b2);
    end
    uart_byte(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic pulse_start();
    @(posedge CLOCK);
    #1 start = 1'b1;
    @(posedge CLOCK);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_we"}, 32'(imem_we), 0);
    check({tag, "_addr"}, 32'(imem_addr), 0);
    check({tag, "_data"}, 32'(imem_data), 0);
    check({tag, "_words"}, 32'(words_loaded), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLOCK);
    check_reset_values("rst");
    RESET_N = 1'b1;
    repeat (CPB * 2) @(negedge CLOCK);

    // single word
    w0 = n_writes;
    wtab[0] = 18'h3FF00;
    send_load(1, 1'b0);
    check("t1_done", 32'(done), 1);
    check("t1_cpu_hold", 32'(cpu_hold), 0);
    check("t1_words", 32'(words_loaded), 1);
    check("t1_err", 32'(err), 0);
    check("t1_writes", n_writes - w0, 1);
    uart_byte(8'h01);
    check("t1_ignored_done", 32'(done), 1);
    check("t1_ignored_words", 32'(words_loaded), 1);
    pulse_start();
    check("t1_start_done", 32'(done), 0);
    check("t1_start_hold", 32'(cpu_hold), 1);
    check("t1_start_words", 32'(words_loaded), 0);

    // two words
    w0 = n_writes;
    wtab[0] = 18'h00001;
    wtab[1] = 18'h20000;
    send_load(2, 1'b0);
    check("t2_done", 32'(done), 1);
    check("t2_words", 32'(words_loaded), 2);
    check("t2_writes", n_writes - w0, 2);
    pulse_start();

    // checksum mismatch
    w0 = n_writes;
    wtab[0] = 18'h3FF00;
    send_load(1, 1'b1);
    check("t3_err", 32'(err), 1);
    check("t3_done", 32'(done), 0);
    check("t3_hold", 32'(cpu_hold), 1);
    check("t3_writes", n_writes - w0, 1);
    pulse_start();
    check("t3_start_err", 32'(err), 0);
    check("t3_start_words", 32'(words_loaded), 0);

    // framing error on second word byte
    w0 = n_writes;
    uart_byte(8'h01);
    uart_byte(8'h00);
    check("t4_pre_err", 32'(err), 0);
    uart_byte(8'hAB, 1'b0);
    check("t4_err", 32'(err), 1);
    check("t4_writes", n_writes - w0, 0);
    pulse_start();
    check("t4_start_err", 32'(err), 0);

    // format errors: byte0 upper bits set, count above 64
    uart_byte(8'h01);
    uart_byte(8'h04);
    check("t5_fmt_b0_err", 32'(err), 1);
    pulse_start();
    uart_byte(8'h41);
    check("t5_fmt_cnt_err", 32'(err), 1);
    pulse_start();
    check("t5_start_err", 32'(err), 0);

    // N=0 means 64 words
    w0 = n_writes;
    for (int i = 0; i < 64; i++) wtab[i] = 18'(i * 4099);
    send_load(64, 1'b0);
    check("t6_words", 32'(words_loaded), 64);
    check("t6_done", 32'(done), 1);
    check("t6_writes", n_writes - w0, 64);
    pulse_start();

    // reset mid-load during WORD_B1
    uart_byte(8'h01);
    uart_byte(8'h00);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1 check_reset_values("midrst");
    rx = 1'b1;
    repeat (5) @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (CPB * 2) @(negedge CLOCK);

    // one-cycle glitch yields no byte
    rx = 1'b0;
    @(negedge CLOCK);
    rx = 1'b1;
    repeat (CPB * 3) @(negedge CLOCK);
    check("t7_glitch_err", 32'(err), 0);
    check("t7_glitch_words", 32'(words_loaded), 0);

    w0 = n_writes;
    wtab[0] = 18'h2A5C3;
    send_load(1, 1'b0);
    check("t7_done", 32'(done), 1);
    check("t7_words", 32'(words_loaded), 1);
    check("t7_writes", n_writes - w0, 1);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the single-cycle CPU's instruction memory. It receives a framed program image over an 8N1 UART line and writes 18-bit instruction words into the 64-entry instruction store. It holds the CPU's PC/register clock gated (`cpu_hold`) until a complete, checksum-verified image has been written, then releases the CPU.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: CLOCK cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `AW`, 6: instruction memory address width (64 words).
- `IW`, 18: instruction width.

Ports:
- `CLOCK` in 1: single clock, 50 MHz.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `rx` in 1: UART serial input, idle high, asynchronous to CLOCK.
- `start` in 1: one-cycle pulse; re-arms the loader from DONE or ERROR.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out AW: write address.
- `imem_data` out IW: write data.
- `cpu_hold` out 1: 1 = CPU must not advance its PC or write state.
- `done` out 1: image loaded and verified.
- `err` out 1: framing, format or checksum error latched.
- `words_loaded` out AW+1: count of words written in the current load.

## Operation
- `rx` passes through a 2-FF synchronizer before any use.
- UART receiver:
  - Idle until a synchronized falling edge.
  - Waits `CLKS_PER_BIT/2` cycles and re-checks for low. If `rx` is high again, this is a glitch: return to idle with no byte.
  - Samples 8 data bits LSB-first at `CLKS_PER_BIT` intervals, then the stop bit.
  - Stop bit = 0 is a framing error.
- Frame format, in byte order:
  - Count byte N. 1..64 words; 0 means 64; values > 64 are a format error.
  - N × 3 bytes per word, big-endian: byte0 bits[1:0] = instr[17:16], byte0 bits[7:2] must be 0 (otherwise format error); byte1 = instr[15:8]; byte2 = instr[7:0].
  - One checksum byte = XOR of the count byte and all word bytes.
- Loader FSM states: IDLE, WORD_B0, WORD_B1, WORD_B2, WRITE, CSUM, DONE, ERROR.
  - IDLE: the first received byte is taken as N → WORD_B0. Count 0 is latched as 64.
  - WORD_B0 → WORD_B1 → WORD_B2: each state advances on one received byte.
  - WORD_B2 → WRITE → WORD_B0 while `words_loaded` < N after increment; otherwise → CSUM.
  - CSUM: on match → DONE; on mismatch → ERROR.
  - Any framing or format error in any receiving state → ERROR immediately.
  - DONE / ERROR: received bytes are ignored. A `start` pulse → IDLE, clears `words_loaded`, `err` and the checksum accumulator.
  - `start` in any other state is ignored.
- Words already written before an error are not rolled back.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_hold`=1, `done`=0, `err`=0, `imem_we`=0.
  - `imem_addr`=0, `imem_data`=0, `words_loaded`=0.
  - Receiver idle, accumulator 0.
- Byte-valid pulses for one cycle, one cycle after the stop-bit sample.
- `imem_we` is high for exactly one cycle (WRITE state), the cycle after the byte2 byte-valid pulse.
  - `imem_addr` = `words_loaded` before increment; `imem_data` is stable in the same cycle.
  - `words_loaded` increments on the same edge that ends WRITE.
- `done`=1 and `cpu_hold`=0 from the cycle after the checksum byte-valid pulse (match). Both hold until `start` or reset.
- `err`=1 from the cycle after the offending sample or byte. `cpu_hold` stays 1.
- `start` in DONE: `cpu_hold` returns to 1 and `done` to 0 on the next edge.
- Reset mid-byte or mid-load returns to the reset state immediately (async). A partial byte is discarded.
- Address wrap: N=64 writes addresses 0..63. `words_loaded` reaches 64 without wrap, since the port is AW+1 bits wide.

## Test plan
- Single word: bytes 01, 03, FF, 00, checksum 01^03^FF^00=FD → one write with addr 0, data 3FF00. Then `done`=1, `cpu_hold`=0, `words_loaded`=1.
- Two words 00001 and 20000: bytes 02, 00, 00, 01, 02, 00, 00, checksum 01 → writes at addr 0 and addr 1, then `done`.
- Checksum mismatch: the first case with a checksum of FC → one write occurs, then `err`=1, `done`=0, `cpu_hold`=1. A `start` pulse clears `err` and returns to IDLE.
- Framing error: stop bit driven 0 on the second word byte → `err`=1 one cycle after the stop sample, with no `imem_we`. Byte0 = 04 (upper bits set) → format error.
- N=0: 64 words with incrementing data → addresses 0..63 written in order, `words_loaded`=64, then `done`.
- Reset mid-load: assert `RESET_N`=0 during WORD_B1 → all outputs at reset values in the same cycle. A fresh single-word frame then loads correctly. A 1-cycle `rx` low glitch produces no byte.
